// File: rtl/capture_pkg.sv
// capture_pkg -- shared widths and FIFO entry type for capture_sync_fifo.
//   CODE_W  : width of a captured code
//   TS_W    : width of the optional capture timestamp
//   entry_t : one FIFO entry (code, plus timestamp when CAPTURE_TIMESTAMP_EN
//             is defined)
package capture_pkg;

    localparam int CODE_W = 4;
    localparam int TS_W   = 16;

    typedef struct packed {
`ifdef CAPTURE_TIMESTAMP_EN
        logic [TS_W-1:0]   ts;
`endif
        logic [CODE_W-1:0] code;
    } entry_t;

endpackage

// File: rtl/capture_sync_fifo_if.sv
// capture_sync_fifo_if -- consumer-side bundle of capture_sync_fifo.
//   out_valid     : FIFO head holds a code
//   out_ready     : consumer accepts the head this cycle
//   out_code      : code at FIFO head
//   count         : current occupancy
//   overflow      : sticky, a capture event was dropped
//   out_timestamp : head timestamp (only with CAPTURE_TIMESTAMP_EN)
// master = FIFO side, slave = consumer side.
interface capture_sync_fifo_if #(
    parameter int DEPTH = 8
);
    import capture_pkg::*;

    logic                     out_valid;
    logic                     out_ready;
    logic [CODE_W-1:0]        out_code;
    logic [$clog2(DEPTH):0]   count;
    logic                     overflow;
`ifdef CAPTURE_TIMESTAMP_EN
    logic [TS_W-1:0]          out_timestamp;

    modport master (output out_valid, out_code, count, overflow, out_timestamp,
                    input  out_ready);
    modport slave  (input  out_valid, out_code, count, overflow, out_timestamp,
                    output out_ready);
`else
    modport master (output out_valid, out_code, count, overflow,
                    input  out_ready);
    modport slave  (input  out_valid, out_code, count, overflow,
                    output out_ready);
`endif

endinterface

// File: rtl/sync_chain.sv
// sync_chain -- plain flop chain used to bring an asynchronous bus into clk.
//   clk, reset : clock, synchronous active-high reset (clears every stage)
//   d          : asynchronous input
//   q          : output of the last stage
module sync_chain #(
    parameter int STAGES = 2,
    parameter int WIDTH  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [STAGES-1:0][WIDTH-1:0] stg;

    always_ff @(posedge clk) begin
        if (reset) begin
            stg <= '0;
        end else begin
            stg[0] <= d;
            for (int i = 1; i < STAGES; i++) stg[i] <= stg[i-1];
        end
    end

    assign q = stg[STAGES-1];

endmodule

// File: rtl/capture_sync_fifo.sv
// capture_sync_fifo -- synchronizes an asynchronous capture flag/code pair,
// turns each flag rising edge into one push, and buffers the codes in a
// first-word fall-through FIFO.
//   clk, reset        : clock, synchronous active-high reset
//   flag_async        : asynchronous capture flag
//   code_async        : captured code, stable while flag_async is high
//   out (master)      : out_valid/out_ready/out_code/count/overflow
//                       (+ out_timestamp)
// Optional feature: define CAPTURE_TIMESTAMP_EN to stamp every entry with a
// free-running 16-bit cycle count and expose it as out.out_timestamp.
module capture_sync_fifo
    import capture_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flag_async,
    input  logic [CODE_W-1:0]          code_async,
    capture_sync_fifo_if.master        out
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // ---------------- synchronizers ----------------
    logic              flag_s;
    logic [CODE_W-1:0] code_s;

    sync_chain #(.STAGES(SYNC_STAGES), .WIDTH(1)) u_flag_sync (
        .clk(clk), .reset(reset), .d(flag_async), .q(flag_s)
    );
    sync_chain #(.STAGES(SYNC_STAGES), .WIDTH(CODE_W)) u_code_sync (
        .clk(clk), .reset(reset), .d(code_async), .q(code_s)
    );

    // ---------------- edge detect ----------------
    // The detected edge is registered together with its code so the push
    // happens on the following edge; this gives the fixed SYNC_STAGES+2
    // latency and keeps the FIFO write path off the edge-detect logic.
    logic              flag_prev;
    logic              evt;
    logic [CODE_W-1:0] evt_code;

    always_ff @(posedge clk) begin
        if (reset) begin
            flag_prev <= 1'b0;
            evt       <= 1'b0;
            evt_code  <= '0;
        end else begin
            flag_prev <= flag_s;
            evt       <= flag_s & ~flag_prev;
            evt_code  <= code_s;
        end
    end

`ifdef CAPTURE_TIMESTAMP_EN
    logic [TS_W-1:0] ts_cnt;

    always_ff @(posedge clk) begin
        if (reset) ts_cnt <= '0;
        else       ts_cnt <= ts_cnt + TS_W'(1);
    end
`endif

    // ---------------- FIFO ----------------
    entry_t           mem [DEPTH];
    entry_t           wr_e;
    entry_t           head;
    logic [PTR_W-1:0] wptr, rptr;
    logic [CNT_W-1:0] cnt;
    logic             ovf;
    logic             full, pop, push, drop;

    assign full = (cnt == CNT_W'(DEPTH));
    assign pop  = (cnt != '0) && out.out_ready;
    // A full FIFO still accepts the new code when the head leaves this cycle.
    assign push = evt && (!full || pop);
    assign drop = evt && full && !pop;

    always_comb begin
        wr_e      = '0;
        wr_e.code = evt_code;
`ifdef CAPTURE_TIMESTAMP_EN
        wr_e.ts   = ts_cnt;
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset && push) mem[wptr] <= wr_e;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
            ovf  <= 1'b0;
        end else begin
            if (push) wptr <= wptr + PTR_W'(1);
            if (pop)  rptr <= rptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
            if (drop) ovf <= 1'b1;
        end
    end

    assign head          = mem[rptr];
    assign out.out_valid = (cnt != '0);
    assign out.out_code  = out.out_valid ? head.code : '0;
    assign out.count     = cnt;
    assign out.overflow  = ovf;
`ifdef CAPTURE_TIMESTAMP_EN
    assign out.out_timestamp = out.out_valid ? head.ts : '0;
`endif

endmodule

// File: doc/capture_sync_fifo.md
CAPTURE_SYNC_FIFO -- requirements
Module: capture_sync_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO entry count (power of two, 2..16).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchronizer flop count (2..4).
REQ-003 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port flag_async  input  1  asynchronous capture flag from the upstream capture stage.
REQ-006 SHALL have port code_async  input  4  captured code; stable while flag_async is high.
REQ-007 SHALL have port out_valid  output  1  FIFO head holds a code.
REQ-008 SHALL have port out_ready  input  1  consumer accepts the head this cycle.
REQ-009 SHALL have port out_code  output  4  code at FIFO head.
REQ-010 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy.
REQ-011 SHALL have port overflow  output  1  sticky: a capture event was dropped.

Function
REQ-012 SHALL pass flag_async and code_async through SYNC_STAGES flops each; no other logic may touch the unsynchronized signals.
REQ-013 SHALL detect an event when the last synchronized flag stage is 1 and its registered previous value is 0; exactly one event per flag_async rising edge.
REQ-014 SHALL write the synchronized code into the FIFO on the event cycle's clock edge.
REQ-015 SHALL be first-word fall-through: out_valid=1 and out_code=head entry whenever count>0.
REQ-016 SHALL pop on out_valid && out_ready; out_ready while out_valid=0 SHALL have no effect.
REQ-017 SHALL give latency of exactly SYNC_STAGES+2 clk rising edges from the first edge sampling flag_async=1 to out_valid=1, with FIFO empty.
REQ-018 SHALL wrap read/write pointers modulo DEPTH; count = writes minus pops, never above DEPTH.
REQ-019 SHALL, on event with count=DEPTH and no pop that cycle, drop the code, leave FIFO unchanged, set overflow=1.
REQ-020 SHALL, on event with count=DEPTH and a pop that same cycle, perform both; count stays DEPTH; overflow unchanged.
REQ-021 SHALL, on event with count=0 and out_ready=1, only push (no pop); count becomes 1.
REQ-022 SHALL push codes verbatim, including 0.
REQ-023 SHALL hold overflow at 1 until reset.

Reset
REQ-024 SHALL, on reset=1 at a clk edge, clear all sync flops, previous-flag register, pointers, count, overflow to 0; out_valid=0, out_code=0.
REQ-025 SHALL, on reset mid-operation, discard all stored entries and any in-flight synchronized event.
REQ-026 SHALL treat flag_async held high through reset release as one new event after release.

Configuration
REQ-027 SHALL, with CAPTURE_TIMESTAMP_EN defined, add a free-running 16-bit cycle counter (reset 0, wraps 0xFFFF->0), store its value with each entry at push, and expose output out_timestamp (16 bits) aligned with out_code.
REQ-028 SHALL, without CAPTURE_TIMESTAMP_EN, omit the counter, the out_timestamp port and the timestamp storage; entries are 4 bits.

Structure
REQ-029 SHALL place CODE_W=4, TS_W=16 and the entry typedef (code, optional timestamp) in shared package capture_pkg.
REQ-030 SHALL implement the synchronizer as sub-module sync_chain (parameter STAGES, WIDTH), instantiated once for flag and once for code.

Verification
REQ-031 SHALL cover: reset, pulse flag_async with code 4'h5, out_ready=0 -> out_valid rises SYNC_STAGES+2 edges later, out_code=5, count=1.
REQ-032 SHALL cover: 8 events codes 1..8, out_ready=0, then a 9th with code 9 -> count=8, overflow=1, drain yields 1..8 in order, 9 absent.
REQ-033 SHALL cover: FIFO full, event coincident with pop -> count stays 8, overflow=0, new code appears last in drain.
REQ-034 SHALL cover: flag_async held high across reset, codes 4'hA stored pre-reset -> FIFO empty after reset, then exactly one entry 4'hA.
REQ-035 SHALL cover: flag_async held high 20 cycles -> exactly one entry; out_ready=1 when empty -> count stays 0.
REQ-036 SHALL cover (CAPTURE_TIMESTAMP_EN): events 10 cycles apart -> out_timestamp values differ by 10, including across 0xFFFF wrap.
